// File: rtl/gpu_cmd_arbiter.sv
// gpu_cmd_arbiter: round-robin burst arbiter sharing one GPU run/ready command port between two FIFO-fed requesters
module gpu_cmd_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [31:0]      req0_data,
    input  logic             req0_sprite,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_data,
    input  logic             req1_sprite,
    input  logic             req1_last,
    output logic             req1_ready,
    input  logic             gpu_ready,
    output logic [31:0]      gpu_instruction,
    output logic             gpu_run,
    output logic             gpu_isSpriteData,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] issued_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t        state, state_nx;
    logic [1:0]    vin, full, empty, avail, ok, pop;
    logic [33:0]   din [2];
    logic [33:0]   head [2];
    logic          gport, grant, abort, done;
    logic          lock_on, lock_port, rr, aborted;
    logic [WW-1:0] wd;

    assign vin        = {req1_valid, req0_valid};
    assign din[0]     = {req0_sprite, req0_last, req0_data};
    assign din[1]     = {req1_sprite, req1_last, req1_data};
    assign req0_ready = !full[0];
    assign req1_ready = !full[1];
    assign busy       = (state != IDLE) || !(&empty);

    // Entry layout {sprite,last,data}; avail lags emptiness by a cycle so a fresh push is seen one cycle later
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [33:0] mem [FIFO_DEPTH];
        logic [AW:0] wp, rp;
        logic        av, push;
        assign push     = vin[g] && !full[g];
        assign full[g]  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        assign empty[g] = wp == rp;
        assign head[g]  = mem[rp[AW-1:0]];
        assign avail[g] = av;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wp <= '0;
                rp <= '0;
                av <= 1'b0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop[g]) rp <= rp + 1'b1;
                av <= !empty[g];
            end
        end
        always_ff @(posedge clk) begin
            if (push) mem[wp[AW-1:0]] <= din[g];
        end
    end

    always_comb begin
        ok       = avail & ~empty;
        gport    = lock_on ? lock_port : (ok[rr] ? rr : ~rr);
        grant    = (state == IDLE) && gpu_ready && ok[gport];
        abort    = (state == ISSUE) && gpu_ready && (wd == WW'(TIMEOUT - 1));
        done     = (state == RELEASE) && gpu_ready;
        pop      = grant ? (2'b01 << gport) : 2'b00;
        state_nx = grant ? ISSUE :
                   (state == ISSUE && (!gpu_ready || abort)) ? RELEASE :
                   done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            gpu_instruction  <= '0;
            gpu_isSpriteData <= 1'b0;
            gpu_run          <= 1'b0;
            lock_on          <= 1'b0;
            lock_port        <= 1'b0;
            rr               <= 1'b0;
            wd               <= '0;
            aborted          <= 1'b0;
            timeout_err      <= 1'b0;
            issued_count     <= '0;
        end else begin
            state       <= state_nx;
            timeout_err <= abort || (timeout_err && !err_clr);
            if (grant) begin
                gpu_instruction  <= head[gport][31:0];
                gpu_isSpriteData <= head[gport][33];
                gpu_run          <= 1'b1;
                wd               <= '0;
                aborted          <= 1'b0;
                lock_on          <= !head[gport][32];
                lock_port        <= gport;
                if (head[gport][32]) rr <= ~gport;
            end
            if (state == ISSUE && state_nx == RELEASE) gpu_run <= 1'b0;
            else if (state == ISSUE) wd <= wd + 1'b1;
            if (abort) aborted <= 1'b1;
            if (done && !aborted) issued_count <= issued_count + 1'b1;
        end
    end
endmodule
